// File: rtl/fp_mul_seq_pkg.sv
// ----------------------------------------------------------------------------
// fp_mul_seq_pkg
// Shared definitions for the sequential floating-point multiplier:
//   - default exponent / mantissa field widths
//   - helpers deriving the exponent bias and the all-ones exponent code
//     (used for both Inf and NaN) from the exponent width
//   - FSM state encoding
// ----------------------------------------------------------------------------
package fp_mul_seq_pkg;

    localparam int DEF_EXP_SIZE    = 8;
    localparam int DEF_MANTIS_SIZE = 23;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL,
        NORM,
        DONE
    } state_t;

    // Exponent bias: 2^(exp_size-1) - 1
    function automatic int calc_bias(input int exp_size);
        return (1 << (exp_size - 1)) - 1;
    endfunction

    // All-ones exponent code shared by Inf and NaN encodings
    function automatic int exp_ones(input int exp_size);
        return (1 << exp_size) - 1;
    endfunction

endpackage

// File: rtl/fp_mant_shift_add.sv
// ----------------------------------------------------------------------------
// fp_mant_shift_add
// Bit-serial mantissa multiplier datapath. On load the multiplicand and
// multiplier are captured and the accumulator/counter cleared; each step
// consumes one multiplier bit, adding the multiplicand shifted by the current
// bit position into the accumulator.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - capture mcand_in / mplier_in, clear accumulator and counter
//   step       - process one multiplier bit
//   mcand_in   - multiplicand (hidden bit included), M bits
//   mplier_in  - multiplier (hidden bit included), M bits
//   prod_top   - upper M+1 bits of the 2M-bit product (all normalisation needs)
//   last       - high while the final multiplier bit is being processed
// ----------------------------------------------------------------------------
module fp_mant_shift_add #(
    parameter int M = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [M-1:0] mcand_in,
    input  logic [M-1:0] mplier_in,
    output logic [M:0]   prod_top,
    output logic         last
);

    localparam int CW = $clog2(M + 1);

    logic [M-1:0]   mcand;
    logic [M-1:0]   mplier;
    logic [2*M-1:0] acc;
    logic [CW-1:0]  count;

    // Multiplier is shifted right so its LSB is always the bit being weighed;
    // the counter supplies that bit's weight for the multiplicand shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + ({{M{1'b0}}, mcand} << count);
            end
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

    assign last     = (count == CW'(M - 1));
    assign prod_top = acc[2*M-1:M-1];

endmodule

// File: rtl/fp_split.sv
// ----------------------------------------------------------------------------
// fp_split
// Packed-number splitter: breaks a {sign, exponent, mantissa} word into its
// three fields. Purely combinational.
// Ports:
//   num    - packed operand
//   sign   - sign bit
//   expo   - biased exponent field
//   mantis - stored mantissa (hidden bit not included)
// ----------------------------------------------------------------------------
module fp_split
    import fp_mul_seq_pkg::*;
#(
    parameter int EXP_SIZE    = DEF_EXP_SIZE,
    parameter int MANTIS_SIZE = DEF_MANTIS_SIZE
) (
    input  logic [EXP_SIZE+MANTIS_SIZE:0] num,
    output logic                          sign,
    output logic [EXP_SIZE-1:0]           expo,
    output logic [MANTIS_SIZE-1:0]        mantis
);

    assign {sign, expo, mantis} = num;

endmodule

// File: rtl/fp_mul_seq.sv
// ----------------------------------------------------------------------------
// fp_mul_seq
// Multi-cycle floating-point multiplier. Operands are latched on start,
// classified for special values (zero / Inf / NaN, no denormals), and normal
// operands go through a one-bit-per-cycle mantissa multiply followed by
// normalisation with truncation.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - request pulse, only honoured while idle
//   a, b       - packed operands {sign, exp, mantis}
//   busy       - high whenever an operation is in flight (including DONE)
//   done       - one-cycle pulse when result is valid
//   result     - product, held until the next done
// ----------------------------------------------------------------------------
module fp_mul_seq
    import fp_mul_seq_pkg::*;
#(
    parameter int EXP_SIZE    = DEF_EXP_SIZE,
    parameter int MANTIS_SIZE = DEF_MANTIS_SIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [EXP_SIZE+MANTIS_SIZE:0] a,
    input  logic [EXP_SIZE+MANTIS_SIZE:0] b,
    output logic                          busy,
    output logic                          done,
    output logic [EXP_SIZE+MANTIS_SIZE:0] result
);

    localparam int W  = 1 + EXP_SIZE + MANTIS_SIZE;
    localparam int M  = MANTIS_SIZE + 1;
    localparam int EW = EXP_SIZE + 2;

    localparam logic [EXP_SIZE-1:0]  EXP_MAX = EXP_SIZE'(exp_ones(EXP_SIZE));
    localparam logic signed [EW-1:0] BIAS_S  = EW'(calc_bias(EXP_SIZE));
    localparam logic signed [EW-1:0] E_OVF   = EW'(exp_ones(EXP_SIZE));
    localparam logic signed [EW-1:0] E_ONE   = EW'(1);
    localparam logic [W-1:0]         NAN_VAL =
        {1'b0, EXP_MAX, 1'b1, {(MANTIS_SIZE-1){1'b0}}};

    state_t state;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;

    logic                   sign_a, sign_b;
    logic [EXP_SIZE-1:0]    exp_a, exp_b;
    logic [MANTIS_SIZE-1:0] mant_a, mant_b;

    fp_split #(.EXP_SIZE(EXP_SIZE), .MANTIS_SIZE(MANTIS_SIZE)) u_split_a (
        .num    (op_a),
        .sign   (sign_a),
        .expo   (exp_a),
        .mantis (mant_a)
    );

    fp_split #(.EXP_SIZE(EXP_SIZE), .MANTIS_SIZE(MANTIS_SIZE)) u_split_b (
        .num    (op_b),
        .sign   (sign_b),
        .expo   (exp_b),
        .mantis (mant_b)
    );

    logic sign_r;
    logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    assign sign_r = sign_a ^ sign_b;
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign inf_a  = (exp_a == EXP_MAX) && (mant_a == '0);
    assign inf_b  = (exp_b == EXP_MAX) && (mant_b == '0);
    assign nan_a  = (exp_a == EXP_MAX) && (mant_a != '0);
    assign nan_b  = (exp_b == EXP_MAX) && (mant_b != '0);

    logic         special;
    logic [W-1:0] special_res;

    // Special-value resolution, highest priority first: NaN (incl. Inf x 0),
    // then signed Inf, then signed zero.
    always_comb begin
        special     = 1'b1;
        special_res = NAN_VAL;
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
            special_res = NAN_VAL;
        end else if (inf_a || inf_b) begin
            special_res = {sign_r, EXP_MAX, {MANTIS_SIZE{1'b0}}};
        end else if (zero_a || zero_b) begin
            special_res = {sign_r, {(W-1){1'b0}}};
        end else begin
            special     = 1'b0;
            special_res = '0;
        end
    end

    logic         mul_load;
    logic         mul_step;
    logic         mul_last;
    logic [M:0]   prod_top;

    assign mul_load = (state == CHECK) && !special;
    assign mul_step = (state == MUL);

    fp_mant_shift_add #(.M(M)) u_mant (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (mul_load),
        .step      (mul_step),
        .mcand_in  ({1'b1, mant_a}),
        .mplier_in ({1'b1, mant_b}),
        .prod_top  (prod_top),
        .last      (mul_last)
    );

    logic signed [EW-1:0]   e_sum;
    logic signed [EW-1:0]   e_norm;
    logic [MANTIS_SIZE-1:0] mant_n;
    logic [W-1:0]           norm_res;

    // prod_top[M] is product bit 2M-1: when set the product is in [2,4) and
    // the leading one moves up a place, bumping the exponent. The bits just
    // below the leading one are kept; the rest are truncated.
    always_comb begin
        e_sum    = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
        e_norm   = e_sum;
        mant_n   = prod_top[M-2:0];
        norm_res = '0;
        if (prod_top[M]) begin
            e_norm = e_sum + E_ONE;
            mant_n = prod_top[M-1:1];
        end
        if (e_norm >= E_OVF) begin
            norm_res = {sign_r, EXP_MAX, {MANTIS_SIZE{1'b0}}};
        end else if (e_norm <= 0) begin
            norm_res = {sign_r, {(W-1){1'b0}}};
        end else begin
            norm_res = {sign_r, e_norm[EXP_SIZE-1:0], mant_n};
        end
    end

    // Sequencer. busy/done/result are registered here so they follow the
    // state directly; result is only written on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (special) begin
                        result <= special_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    result <= norm_res;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
